// File: rtl/chebyshev_sequencer.sv
// Sequencer for the iterative Chebyshev/Horner datapath. It owns the coefficient register file,
// holds the sample on dp_x for a whole job, issues c[DEGREE]..c[0] for LAT cycles each, then
// captures dp_result and returns it over a valid/ready handshake.
module chebyshev_sequencer #(
    parameter int unsigned WL       = 16,
    parameter int unsigned CL       = 16,
    parameter int unsigned WIDENING = 3,
    parameter int unsigned DEGREE   = 7,
    parameter int unsigned LAT      = 2,
    localparam int unsigned RW      = 2 * WL + CL + WIDENING,
    localparam int unsigned AW      = $clog2(DEGREE + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cw_en_i,
    input  logic [AW-1:0] cw_addr_i,
    input  logic [CL-1:0] cw_data_i,
    output logic          cw_err_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [WL-1:0] in_data_i,
    output logic [WL-1:0] dp_x_o,
    output logic [CL-1:0] dp_coeff_o,
    output logic          dp_clear_o,
    input  logic [RW-1:0] dp_result_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [RW-1:0] out_data_o,
    output logic          busy_o
);

    localparam int unsigned SW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StIter = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [AW-1:0] KTop    = AW'(DEGREE);
    localparam logic [AW:0]   MaxAddr = (AW + 1)'(DEGREE);
    localparam logic [SW-1:0] SubLast = SW'(LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [CL-1:0] rf_q [DEGREE+1];
    logic [WL-1:0] dp_x_q, dp_x_d;
    logic [CL-1:0] dp_coeff_q, dp_coeff_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] k_q, k_d;
    logic [SW-1:0] sub_q, sub_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          cw_err_q, cw_err_d;

    logic addr_ok, wr_ok, accept, sub_wrap, last_iter;

    // Decode write legality, input accept and iteration position.
    always_comb begin
        addr_ok   = ({1'b0, cw_addr_i} <= MaxAddr);
        wr_ok     = cw_en_i && (state_q == StIdle) && addr_ok;
        accept    = in_valid_i && in_ready_q;
        sub_wrap  = (sub_q == SubLast);
        last_iter = (state_q == StIter) && (k_q == '0) && sub_wrap;
        cw_err_d  = cw_en_i && !wr_ok;
    end

    // FSM next state and datapath control registers.
    always_comb begin
        state_d     = state_q;
        dp_x_d      = dp_x_q;
        dp_coeff_d  = dp_coeff_q;
        out_data_d  = out_data_q;
        k_d         = k_q;
        sub_d       = sub_q;
        out_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIter;
                    dp_x_d  = in_data_i;
                    k_d     = KTop;
                    sub_d   = '0;
                    // A write landing on this same edge must be seen by the job.
                    dp_coeff_d = (wr_ok && (cw_addr_i == KTop)) ? cw_data_i : rf_q[DEGREE];
                end
            end
            StIter: begin
                if (sub_wrap) begin
                    sub_d = '0;
                    if (k_q != '0) begin
                        k_d        = k_q - 1'b1;
                        dp_coeff_d = rf_q[k_q - 1'b1];
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
                if (last_iter) begin
                    state_d    = StDone;
                    out_data_d = dp_result_i;
                end
            end
            StDone: begin
                // First DONE cycle is the capture cycle; valid rises after it.
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready_i) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d = (state_d == StIdle);
    end

    // Coefficient register file; writes only land while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i <= DEGREE; i++) rf_q[i] <= '0;
        end else if (wr_ok) begin
            rf_q[cw_addr_i] <= cw_data_i;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            dp_x_q      <= '0;
            dp_coeff_q  <= '0;
            out_data_q  <= '0;
            k_q         <= '0;
            sub_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cw_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dp_x_q      <= dp_x_d;
            dp_coeff_q  <= dp_coeff_d;
            out_data_q  <= out_data_d;
            k_q         <= k_d;
            sub_q       <= sub_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cw_err_q    <= cw_err_d;
        end
    end

    // Output drive.
    always_comb begin
        cw_err_o    = cw_err_q;
        in_ready_o  = in_ready_q;
        dp_x_o      = dp_x_q;
        dp_coeff_o  = dp_coeff_q;
        dp_clear_o  = (state_q == StIter) && (k_q == KTop);
        out_valid_o = out_valid_q;
        out_data_o  = out_data_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Self-checking bench for chebyshev_sequencer: cycle-by-cycle checks of the coefficient issue
// order, clear timing, result capture and handshakes against a Horner reference model.
module tb_chebyshev_sequencer;

    localparam int unsigned WL       = 16;
    localparam int unsigned CL       = 16;
    localparam int unsigned WIDENING = 3;
    localparam int unsigned DEGREE   = 5;
    localparam int unsigned LAT      = 3;
    localparam int unsigned RW       = 2 * WL + CL + WIDENING;
    localparam int unsigned AW       = $clog2(DEGREE + 1);
    localparam int          N        = (DEGREE + 1) * LAT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cw_en;
    logic [AW-1:0] cw_addr;
    logic [CL-1:0] cw_data;
    logic          cw_err;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_data;
    logic [WL-1:0] dp_x;
    logic [CL-1:0] dp_coeff;
    logic          dp_clear;
    logic [RW-1:0] dp_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference coefficient file as the spec defines it.
    logic signed [CL-1:0] rf_m [DEGREE+1];

    always #5 clk = ~clk;

    chebyshev_sequencer #(
        .WL      (WL),
        .CL      (CL),
        .WIDENING(WIDENING),
        .DEGREE  (DEGREE),
        .LAT     (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cw_en_i    (cw_en),
        .cw_addr_i  (cw_addr),
        .cw_data_i  (cw_data),
        .cw_err_o   (cw_err),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .dp_x_o     (dp_x),
        .dp_coeff_o (dp_coeff),
        .dp_clear_o (dp_clear),
        .dp_result_i(dp_result),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Horner evaluation of the polynomial in RW-bit two's complement.
    function automatic logic [RW-1:0] horner(input logic signed [WL-1:0] x);
        logic signed [RW-1:0] acc;
        logic signed [RW-1:0] xs;
        logic signed [RW-1:0] cs;
        xs  = RW'(x);
        acc = '0;
        for (int k = DEGREE; k >= 0; k--) begin
            cs  = RW'(rf_m[k]);
            acc = acc * xs + cs;
        end
        return acc;
    endfunction

    // Called at a negedge while idle; ends at a negedge with the write complete.
    task automatic cw_write(input logic [AW-1:0] a, input logic [CL-1:0] d);
        bit bad;
        bad     = (int'(a) > int'(DEGREE));
        cw_en   = 1'b1;
        cw_addr = a;
        cw_data = d;
        @(negedge clk);
        cw_en = 1'b0;
        check_eq("cw_err", 64'(cw_err), 64'(bad));
        if (!bad) rf_m[a] = d;
        @(negedge clk);
        check_eq("cw_err_pulse_end", 64'(cw_err), 64'(0));
    endtask

    // One complete job. Called at a negedge while idle; returns at a negedge back in idle.
    task automatic run_job(input logic [WL-1:0] x, input int hold, input bit mid_write,
                           input bit same_write, input logic [AW-1:0] s_addr,
                           input logic [CL-1:0] s_data);
        logic [RW-1:0] gold;
        check_eq("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = x;
        if (same_write) begin
            cw_en   = 1'b1;
            cw_addr = s_addr;
            cw_data = s_data;
            if (int'(s_addr) <= int'(DEGREE)) rf_m[s_addr] = s_data;
        end
        gold = horner(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = WL'($urandom);
        cw_en    = 1'b0;
        for (int i = 0; i < N; i++) begin
            check_eq("dp_coeff", 64'(dp_coeff), 64'($unsigned(rf_m[DEGREE - i / LAT])));
            check_eq("dp_clear", 64'(dp_clear), 64'(i < LAT));
            check_eq("dp_x", 64'(dp_x), 64'(x));
            check_eq("busy_iter", 64'(busy), 64'(1));
            check_eq("in_ready_iter", 64'(in_ready), 64'(0));
            check_eq("out_valid_iter", 64'(out_valid), 64'(0));
            if (mid_write && i == 3) check_eq("cw_err_iter", 64'(cw_err), 64'(1));
            // Datapath result becomes meaningful only on the last iteration cycle.
            dp_result = (i == N - 1) ? gold : RW'({$urandom, $urandom});
            if (mid_write && i == 2) begin
                cw_en   = 1'b1;
                cw_addr = '0;
                cw_data = CL'(7);
            end else begin
                cw_en = 1'b0;
            end
            @(negedge clk);
        end
        dp_result = RW'({$urandom, $urandom});
        check_eq("out_valid_capture", 64'(out_valid), 64'(0));
        check_eq("busy_capture", 64'(busy), 64'(1));
        out_ready = 1'b0;
        @(negedge clk);
        for (int h = 0; h < hold; h++) begin
            check_eq("out_valid_hold", 64'(out_valid), 64'(1));
            check_eq("out_data_hold", 64'(out_data), 64'(gold));
            check_eq("in_ready_hold", 64'(in_ready), 64'(0));
            in_valid  = 1'b1;
            in_data   = WL'($urandom);
            dp_result = RW'({$urandom, $urandom});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("out_valid", 64'(out_valid), 64'(1));
        check_eq("out_data", 64'(out_data), 64'(gold));
        check_eq("busy_done", 64'(busy), 64'(1));
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("out_valid_after", 64'(out_valid), 64'(0));
        check_eq("busy_after", 64'(busy), 64'(0));
        check_eq("in_ready_after", 64'(in_ready), 64'(1));
    endtask

    task automatic check_all_zero();
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_dp_clear", 64'(dp_clear), 64'(0));
        check_eq("rst_cw_err", 64'(cw_err), 64'(0));
        check_eq("rst_dp_coeff", 64'(dp_coeff), 64'(0));
        check_eq("rst_dp_x", 64'(dp_x), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        cw_en     = 1'b0;
        cw_addr   = '0;
        cw_data   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        dp_result = '0;
        out_ready = 1'b0;
        for (int i = 0; i <= int'(DEGREE); i++) rf_m[i] = '0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_pre_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_eq("in_ready_post_reset", 64'(in_ready), 64'(1));

        // Directed: c = {1,2,3,4} on the low terms, x = 5 gives 586.
        cw_write(AW'(0), CL'(1));
        cw_write(AW'(1), CL'(2));
        cw_write(AW'(2), CL'(3));
        cw_write(AW'(3), CL'(4));
        run_job(WL'(5), 0, 1'b0, 1'b0, '0, '0);

        // Output stall with a competing input request.
        run_job(WL'(5), 10, 1'b0, 1'b0, '0, '0);

        // Write during ITER is rejected.
        run_job(WL'(5), 0, 1'b1, 1'b0, '0, '0);

        // Out-of-range addresses are rejected.
        cw_write(AW'(DEGREE + 1), CL'(16'h1234));
        cw_write(AW'(7), CL'(16'h5678));

        // Write to the top coefficient on the accept edge is used by that job.
        run_job(WL'(5), 0, 1'b0, 1'b1, AW'(DEGREE), CL'(9));

        // Randomized jobs, many back-to-back.
        for (int j = 0; j < 10; j++) begin
            if ($urandom_range(0, 1) == 1) begin
                cw_write(AW'($urandom_range(0, 7)), CL'($urandom));
            end
            run_job(WL'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), CL'($urandom));
        end

        // Reset in the middle of ITER aborts the job and clears the file.
        in_valid = 1'b1;
        in_data  = WL'(16'h0abc);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero();
        for (int i = 0; i <= int'(DEGREE); i++) rf_m[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_pre_edge2", 64'(in_ready), 64'(0));
        @(negedge clk);
        check_eq("in_ready_post_reset2", 64'(in_ready), 64'(1));
        check_eq("out_valid_aborted", 64'(out_valid), 64'(0));
        cw_write(AW'(0), CL'(3));
        run_job(WL'(16'hfff0), 0, 1'b0, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
